// File: rtl/conv_acc_pkg.sv
// Shared constants and types for the convolution accelerator IFM datapath.
// Bus widths, the word-to-slice ratio helper and the converter FSM state.
package conv_acc_pkg;

    localparam int IFM_BUS_WIDTH = 512;
    localparam int IFM_WIDTH     = 64;

    function automatic int ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    typedef enum logic {
        IDLE,
        RUN
    } conv_state_e;

endpackage

// File: rtl/ifm_width_converter.sv
// Pops IN_WIDTH words from the IFM FIFO and streams them LSB-first as OUT_WIDTH
// slices over valid/ready, tagging the first and last slice of each frame.
module ifm_width_converter
    import conv_acc_pkg::*;
#(
    parameter int IN_WIDTH  = IFM_BUS_WIDTH,
    parameter int OUT_WIDTH = IFM_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 frame_start,
    input  logic [CNT_WIDTH-1:0] frame_words,
    input  logic                 fifo_empty,
    output logic                 fifo_pop_req,
    input  logic [IN_WIDTH-1:0]  fifo_pop_data,
    output logic [OUT_WIDTH-1:0] out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RATIO = ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    conv_state_e          state_q, state_d;
    logic [IN_WIDTH-1:0]  sr_q, sr_d;
    logic                 sr_valid_q, sr_valid_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_WIDTH-1:0]  pf_q, pf_d;
    logic                 pf_valid_q, pf_valid_d;
    logic [CNT_WIDTH-1:0] fetch_rem_q, fetch_rem_d;
    logic [CNT_WIDTH-1:0] emit_rem_q, emit_rem_d;
    logic                 pop_inflight_q, pop_inflight_d;
    logic                 fifo_pop_req_q, fifo_pop_req_d;
    logic                 first_q, first_d;

    logic handshake;
    logic drain;
    logic sr_free;
    logic pf_to_sr;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q        <= IDLE;
            sr_q           <= '0;
            sr_valid_q     <= 1'b0;
            idx_q          <= '0;
            pf_q           <= '0;
            pf_valid_q     <= 1'b0;
            fetch_rem_q    <= '0;
            emit_rem_q     <= '0;
            pop_inflight_q <= 1'b0;
            fifo_pop_req_q <= 1'b0;
            first_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            sr_valid_q     <= sr_valid_d;
            idx_q          <= idx_d;
            pf_q           <= pf_d;
            pf_valid_q     <= pf_valid_d;
            fetch_rem_q    <= fetch_rem_d;
            emit_rem_q     <= emit_rem_d;
            pop_inflight_q <= pop_inflight_d;
            fifo_pop_req_q <= fifo_pop_req_d;
            first_q        <= first_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        sr_valid_d     = sr_valid_q;
        idx_d          = idx_q;
        pf_d           = pf_q;
        pf_valid_d     = pf_valid_q;
        fetch_rem_d    = fetch_rem_q;
        emit_rem_d     = emit_rem_q;
        first_d        = first_q;
        pop_inflight_d = fifo_pop_req_q;

        handshake = sr_valid_q && out_tready;
        drain     = handshake && (idx_q == IDX_LAST);
        sr_free   = !sr_valid_q || drain;
        pf_to_sr  = sr_free && pf_valid_q;

        case (state_q)
            IDLE: begin
                if (frame_start && (frame_words != '0)) begin
                    state_d     = RUN;
                    fetch_rem_d = frame_words;
                    emit_rem_d  = frame_words;
                    first_d     = 1'b1;
                end
            end
            RUN: begin
                if (drain && (emit_rem_q == CNT_WIDTH'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only one word may be in flight so a free slot is guaranteed on arrival.
        fifo_pop_req_d = (state_q == RUN) && (fetch_rem_q != '0) && !fifo_empty &&
                         !pop_inflight_q && !fifo_pop_req_q && (!pf_valid_q || pf_to_sr);
        if (fifo_pop_req_d) begin
            fetch_rem_d = fetch_rem_q - CNT_WIDTH'(1);
        end

        if (handshake) begin
            sr_d  = sr_q >> OUT_WIDTH;
            idx_d = drain ? '0 : idx_q + IDX_W'(1);
        end
        if (drain) begin
            emit_rem_d = emit_rem_q - CNT_WIDTH'(1);
            first_d    = 1'b0;
        end

        // The prefetched word always enters sr ahead of newly arriving pop data.
        if (sr_free) begin
            if (pf_valid_q) begin
                sr_d       = pf_q;
                sr_valid_d = 1'b1;
                pf_valid_d = pop_inflight_q;
                if (pop_inflight_q) begin
                    pf_d = fifo_pop_data;
                end
            end else if (pop_inflight_q) begin
                sr_d       = fifo_pop_data;
                sr_valid_d = 1'b1;
            end else begin
                sr_valid_d = 1'b0;
            end
        end else if (pop_inflight_q) begin
            pf_d       = fifo_pop_data;
            pf_valid_d = 1'b1;
        end
    end

    assign fifo_pop_req = fifo_pop_req_q;
    assign out_tvalid   = sr_valid_q;
    assign out_tdata    = sr_q[OUT_WIDTH-1:0];
    assign out_first    = sr_valid_q && first_q && (idx_q == '0);
    assign out_last     = sr_valid_q && (idx_q == IDX_LAST) && (emit_rem_q == CNT_WIDTH'(1));
    assign busy         = (state_q == RUN);

endmodule

// File: doc/ifm_width_converter.md
Name: ifm_width_converter

Overview:
- Sits between the 512-bit IFM FIFO and the convolution engine in each conv_inst lane.
- Pops full-width IFM words from the FIFO and emits them as a stream of IFM_WIDTH slices under a valid/ready handshake.
- Marks the first slice and the last slice of each frame.
- Runs at one slice per cycle while the FIFO is non-empty and the consumer is ready.

Parameters:
- IN_WIDTH, 512, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, slice width delivered to the engine.
- CNT_WIDTH, 16, width of the frame word counter.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse that starts a frame; accepted only when busy=0.
- frame_words  in  CNT_WIDTH  number of IN_WIDTH words in the frame; sampled with frame_start.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_pop_req  out  1  FIFO POP_REQ.
- fifo_pop_data  in  IN_WIDTH  FIFO POP_DATA; valid in the cycle after fifo_pop_req.
- out_tdata  out  OUT_WIDTH  slice data.
- out_tvalid  out  1  slice valid.
- out_tready  in  1  consumer ready.
- out_first  out  1  qualifies the first slice of the frame.
- out_last  out  1  qualifies the last slice of the frame.
- busy  out  1  high from frame_start acceptance until the last slice handshake.

Behaviour:
- Reset (RESETn=0 at a CLK edge): all outputs 0, state IDLE, counters 0, buffers empty.
  - Reset mid-frame aborts the frame. Any pop data in flight is discarded. The FIFO is reset in the same cycle.
- Derived constant: RATIO = IN_WIDTH/OUT_WIDTH (8).
- Slice order is LSB first: slice k = word[k*OUT_WIDTH +: OUT_WIDTH].
- Internal storage:
  - Shift register sr plus slice index idx (0..RATIO-1).
  - One-entry prefetch buffer pf with valid flag.
  - Fetch counter fetch_rem and emit counter emit_rem, both loaded with frame_words.
  - Flag pop_inflight.
- FSM states:
  - IDLE: busy=0. On frame_start with frame_words!=0, load counters, set busy=1, go to RUN. frame_start with frame_words=0 is ignored (no pop, busy stays 0).
  - RUN: fetch and emit as below. When the slice with out_last=1 handshakes, go to IDLE; busy falls on the next cycle.
- frame_start while busy=1 is ignored.
- fifo_pop_req (registered) is asserted when all of these hold: state=RUN, fetch_rem!=0, !fifo_empty, !pop_inflight, and (pf empty, or a pf transfer into sr occurs this cycle).
  - Never assert fifo_pop_req while fifo_empty=1.
- Data capture:
  - fetch_rem decrements per pop; pop_inflight is set for exactly one cycle.
  - When pop_inflight=1, fifo_pop_data goes to sr if sr is empty or being fully drained this cycle; otherwise it goes to pf.
  - pf moves into sr when sr empties.
- Output:
  - out_tvalid = sr valid; out_tdata = sr slice idx.
  - On a handshake, idx increments. At idx=RATIO-1, sr frees, idx wraps to 0, and emit_rem decrements.
  - out_first = 1 on idx=0 of the first word only.
  - out_last = 1 on idx=RATIO-1 when emit_rem=1.
  - If a frame has one word, the first word is also the last.
- AXIS rule: while out_tvalid=1 and out_tready=0, out_tdata, out_first and out_last hold stable. tvalid never drops without a handshake.
- Latency: frame_start accepted at edge T0 with the FIFO non-empty gives:
  - fifo_pop_req high in cycle T0+1;
  - data captured at the end of T0+2;
  - out_tvalid high in cycle T0+3.
- Throughput: with the FIFO non-empty and out_tready=1, out_tvalid stays high continuously across word boundaries, with no bubble.
- FIFO underflow: if fifo_empty=1, fetching stalls. out_tvalid drops only after sr and pf are exhausted, and resumes 2 cycles after the pop.
- Simultaneous events: an sr drain, a pf transfer and new pop data arriving in one cycle must not lose or reorder words.

Decomposition:
- conv_acc_pkg holds:
  - IFM_BUS_WIDTH=512 and IFM_WIDTH=64;
  - the RATIO function;
  - the typedef enum {IDLE, RUN} for the FSM state.
- No sub-module: the single module fits within about 200 lines.

Test Plan:
- Frame of 1 word 0x...0706050403020100 (byte k = k), out_tready=1 → 8 slices 0x0706050403020100, 0x0F0E0D0C0B0A0908, …; out_first on slice 0 and out_last on slice 7; first tvalid at T0+3; busy falls after the last handshake.
- Frame of 3 words preloaded, out_tready=1 → 24 consecutive valid cycles with no gap, exactly 3 pops, out_last on slice 23 only.
- Backpressure: out_tready toggles 1,0,0,1 repeatedly → data, first and last stable while stalled; total of 8*frame_words handshakes; no extra pops.
- FIFO empty after word 1 of a 2-word frame, refilled 10 cycles later → tvalid drops after slice 7 and returns 2 cycles after the pop; no pop_req while empty.
- frame_start during busy, and frame_start with frame_words=0 → both ignored: no pops, no counter change.
- RESETn=0 mid-frame (slice 3 of 5 words) → next cycle all outputs 0 and IDLE; a following frame_start runs a clean frame with out_first on its first slice.
